branch_history_predictor: RTL

//  Parametrised successor to the fixed branch predictor in the pipelined datapath.

---
 rtl/branch_history_predictor.sv | 77 +++++++
 1 files changed

// File: rtl/branch_history_predictor.sv
// branch_history_predictor: direct-mapped tagged BTB with saturating counters, bimodal/gshare indexing, global history and mispredict counter
module branch_history_predictor #(
  parameter int ENTRIES = 16,
  parameter int TAG_W = 8,
  parameter int CNT_W = 2,
  parameter int HIST_W = 4,
  parameter int MODE = 0,
  parameter int STAT_W = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic [31:0] PC,
  output logic taken,
  output logic select,
  output logic [31:0] nxtPC,
  output logic [HIST_W-1:0] pred_hist,
  input  logic br,
  input  logic br_result,
  input  logic br_pred,
  input  logic [31:0] brPC,
  input  logic [31:0] braddr,
  input  logic [HIST_W-1:0] br_hist,
  output logic [STAT_W-1:0] mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_WT = CNT_W'(1 << (CNT_W - 1));
  logic valid [ENTRIES];
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [CNT_W-1:0] cnt_q [ENTRIES];
  logic [31:0] tgt_q [ENTRIES];
  logic [HIST_W-1:0] ghr;
  logic [IDX_W-1:0] idx, uidx;
  logic [TAG_W-1:0] ltag, utag;
  logic [CNT_W-1:0] ucnt;
  logic hit, uhit, unused;
  function automatic logic [IDX_W-1:0] hidx(input logic [31:0] a, input logic [HIST_W-1:0] h);
    return a[IDX_W+1:2] ^ (MODE != 0 ? IDX_W'(h) : '0);
  endfunction
  assign unused = ^{PC, brPC, br_hist};
  always_comb begin
    idx = hidx(PC, ghr);
    ltag = PC[IDX_W+2 +: TAG_W];
    hit = valid[idx] && tag_q[idx] == ltag;
    taken = hit & cnt_q[idx][CNT_W-1];
    select = taken;
    nxtPC = taken ? tgt_q[idx] : '0;
    pred_hist = ghr;
    uidx = hidx(brPC, br_hist);
    utag = brPC[IDX_W+2 +: TAG_W];
    uhit = valid[uidx] && tag_q[uidx] == utag;
    ucnt = br_result ? (&cnt_q[uidx] ? cnt_q[uidx] : cnt_q[uidx] + 1'b1)
                     : (|cnt_q[uidx] ? cnt_q[uidx] - 1'b1 : cnt_q[uidx]);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        cnt_q[i] <= CNT_WNT;
      end
      ghr <= '0;
      mispredicts <= '0;
    end else if (br) begin
      if (uhit) begin
        cnt_q[uidx] <= ucnt;
        if (br_result) tgt_q[uidx] <= braddr;
      end else if (br_result) begin
        valid[uidx] <= 1'b1;
        tag_q[uidx] <= utag;
        tgt_q[uidx] <= braddr;
        cnt_q[uidx] <= CNT_WT;
      end
      ghr <= (ghr << 1) | HIST_W'(br_result);
      if (br_pred != br_result && !(&mispredicts)) mispredicts <= mispredicts + 1'b1;
    end
  end
endmodule
